// File: rtl/maze_gen_if.sv
// Maze handshake bundle: start/seed request, busy/done status and the maze bit array.
// master is the generator (writer of maze); slave is the controller/consumer side.
interface maze_gen_if #(
  parameter int unsigned size = 19
);
  logic              start;
  logic [15:0]       seed;
  logic              busy;
  logic              done;
  logic [size-1:0]   maze [size-1:0];

  modport master (
    input  start,
    input  seed,
    output busy,
    output done,
    output maze
  );

  modport slave (
    output start,
    output seed,
    input  busy,
    input  done,
    input  maze
  );
endinterface

// File: rtl/maze_generator.sv
// Binary-tree maze generator: fills the grid with walls, then carves one cell per clock
// using a seeded 16-bit LFSR, and finally opens the entrance and exit.
module maze_generator #(
  parameter int unsigned size         = 19,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  maze_gen_if.master mg
);

  localparam int unsigned W = $clog2(size);
  localparam logic [W-1:0] LastRow  = W'(size - 1);
  localparam logic [W-1:0] LastCell = W'(size - 2);
  localparam logic [W-1:0] One      = W'(1);
  localparam logic [W-1:0] Two      = W'(2);

  typedef enum logic [2:0] {StIdle, StFill, StCarve, StOpen, StDone} state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [W-1:0]    row_q, row_d;
  logic [W-1:0]    col_q, col_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [size-1:0] maze_q [size-1:0];
  logic [size-1:0] maze_d [size-1:0];
  logic            lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    row_d   = row_q;
    col_d   = col_q;
    busy_d  = busy_q;
    done_d  = done_q;
    maze_d  = maze_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (mg.start) begin
          lfsr_d  = (mg.seed == 16'h0000) ? SEED_DEFAULT : mg.seed;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          row_d   = '0;
          col_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        maze_d[row_q] = '1;
        if (row_q == LastRow) begin
          row_d   = One;
          col_d   = One;
          state_d = StCarve;
        end else begin
          row_d = row_q + One;
        end
      end
      StCarve: begin
        maze_d[row_q][col_q] = 1'b0;
        // Top row is forced east, last column forced north, the top-right corner gets nothing.
        if (row_q == One && col_q != LastCell) begin
          maze_d[row_q][col_q + One] = 1'b0;
        end else if (col_q == LastCell && row_q != One) begin
          maze_d[row_q - One][col_q] = 1'b0;
        end else if (row_q != One) begin
          if (lfsr_q[0]) begin
            maze_d[row_q - One][col_q] = 1'b0;
          end else begin
            maze_d[row_q][col_q + One] = 1'b0;
          end
        end
        lfsr_d = {lfsr_q[14:0], lfsr_fb};
        if (col_q == LastCell) begin
          if (row_q == LastCell) begin
            state_d = StOpen;
          end else begin
            row_d = row_q + Two;
            col_d = One;
          end
        end else begin
          col_d = col_q + Two;
        end
      end
      StOpen: begin
        maze_d[0][1]           = 1'b0;
        maze_d[size-1][size-2] = 1'b0;
        done_d                 = 1'b1;
        busy_d                 = 1'b0;
        state_d                = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED_DEFAULT;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(size); i++) begin
        maze_q[i] <= '1;
      end
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      maze_q  <= maze_d;
    end
  end

  assign mg.busy = busy_q;
  assign mg.done = done_q;
  assign mg.maze = maze_q;

endmodule

// File: tb/tb_maze_generator.sv
// Directed bench for maze_generator: size=5 golden mazes, size=19 latency, reset,
// restart and structural (border / connectivity / tree) checks over many seeds.
module tb_maze_generator;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  maze_gen_if #(.size(5))  if5 ();
  maze_gen_if #(.size(19)) if19 ();

  maze_generator #(.size(5)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .mg  (if5)
  );

  maze_generator #(.size(19)) u_dut19 (
    .clk (clk),
    .rst (rst),
    .mg  (if19)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] m19 [19];
  logic [18:0] ref_a [19];
  logic [18:0] ref_b [19];

  task automatic snap19();
    for (int r = 0; r < 19; r++) m19[r] = if19.maze[r];
  endtask

  // Accept a start on size-19 and count edges until done (-1 on timeout).
  task automatic run19(input logic [15:0] s, output int lat);
    @(negedge clk);
    if19.start = 1'b1;
    if19.seed  = s;
    @(posedge clk);
    #1;
    if19.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (if19.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run5(input logic [15:0] s, output int lat);
    @(negedge clk);
    if5.start = 1'b1;
    if5.seed  = s;
    @(posedge clk);
    #1;
    if5.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (if5.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Flood fill from the entrance over open positions of m19.
  task automatic flood19(output int cells, output int opens, output bit exit_ok);
    bit seen [19][19];
    int q[$];
    cells   = 0;
    opens   = 0;
    exit_ok = 1'b0;
    for (int r = 0; r < 19; r++) begin
      for (int c = 0; c < 19; c++) begin
        seen[r][c] = 1'b0;
        if (m19[r][c] === 1'b0) opens++;
      end
    end
    if (m19[0][1] === 1'b0) begin
      seen[0][1] = 1'b1;
      q.push_back(1);
    end
    while (q.size() > 0) begin
      int p;
      int r;
      int c;
      p = q.pop_front();
      r = p / 19;
      c = p % 19;
      if ((r % 2 == 1) && (c % 2 == 1)) cells++;
      if (r == 18 && c == 17) exit_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
        int nr;
        int nc;
        nr = r + ((k == 0) ? -1 : (k == 1) ? 1 : 0);
        nc = c + ((k == 2) ? -1 : (k == 3) ? 1 : 0);
        if (nr >= 0 && nr < 19 && nc >= 0 && nc < 19) begin
          if (!seen[nr][nc] && m19[nr][nc] === 1'b0) begin
            seen[nr][nc] = 1'b1;
            q.push_back(nr * 19 + nc);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    bit ones5;
    bit ones19;
    ones5  = 1'b1;
    ones19 = 1'b1;
    for (int r = 0; r < 5; r++) if (if5.maze[r] !== 5'h1F) ones5 = 1'b0;
    for (int r = 0; r < 19; r++) if (if19.maze[r] !== 19'h7FFFF) ones19 = 1'b0;
    checks++;
    if (ones5 !== 1'b1) begin
      errors++;
      $display("FAIL reset_maze5: got not-all-ones, required all ones");
    end
    checks++;
    if (ones19 !== 1'b1) begin
      errors++;
      $display("FAIL reset_maze19: got not-all-ones, required all ones");
    end
    checks++;
    if ({if5.busy, if5.done, if19.busy, if19.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000",
               {if5.busy, if5.done, if19.busy, if19.done});
    end
  endtask

  task automatic test_small_seed1();
    logic [4:0] exp [5];
    int lat;
    exp[0] = 5'b11101; exp[1] = 5'b10001; exp[2] = 5'b10111;
    exp[3] = 5'b10001; exp[4] = 5'b10111;
    @(negedge clk);
    if5.start = 1'b1;
    if5.seed  = 16'h0001;
    @(posedge clk);
    #1;
    if5.start = 1'b0;
    checks++;
    if (if5.busy !== 1'b1 || if5.done !== 1'b0) begin
      errors++;
      $display("FAIL s1_accept: busy=%b done=%b, required busy=1 done=0", if5.busy, if5.done);
    end
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (if5.done === 1'b1) begin
        lat = n;
        break;
      end
      checks++;
      if (if5.busy !== 1'b1) begin
        errors++;
        $display("FAIL s1_busy_edge%0d: busy=%b, required 1", n, if5.busy);
      end
    end
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL s1_latency: got %0d edges, required 10", lat);
    end
    checks++;
    if (if5.busy !== 1'b0) begin
      errors++;
      $display("FAIL s1_busy_at_done: busy=%b, required 0", if5.busy);
    end
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (if5.maze[r] !== exp[r]) begin
        errors++;
        $display("FAIL s1_row%0d: got %b, required %b", r, if5.maze[r], exp[r]);
      end
    end
  endtask

  task automatic test_small_seed4000();
    logic [4:0] exp [5];
    int lat;
    exp[0] = 5'b11101; exp[1] = 5'b10001; exp[2] = 5'b10101;
    exp[3] = 5'b10101; exp[4] = 5'b10111;
    run5(16'h4000, lat);
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL s4000_latency: got %0d edges, required 10", lat);
    end
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (if5.maze[r] !== exp[r]) begin
        errors++;
        $display("FAIL s4000_row%0d: got %b, required %b", r, if5.maze[r], exp[r]);
      end
    end
  endtask

  task automatic test_seed_zero();
    int lat;
    int cells;
    int opens;
    bit exit_ok;
    bit same;
    bit col_ok;
    run19(16'h0000, lat);
    checks++;
    if (lat != 101) begin
      errors++;
      $display("FAIL z_latency: got %0d edges, required 101", lat);
    end
    snap19();
    for (int r = 0; r < 19; r++) ref_a[r] = m19[r];
    checks++;
    if ((m19[1] & 19'h3FFFE) !== 19'h0) begin
      errors++;
      $display("FAIL z_row1: got %b, required cols 1..17 zero", m19[1]);
    end
    col_ok = 1'b1;
    for (int r = 1; r <= 17; r++) if (m19[r][17] !== 1'b0) col_ok = 1'b0;
    checks++;
    if (col_ok !== 1'b1) begin
      errors++;
      $display("FAIL z_col17: got a wall in rows 1..17, required all open");
    end
    flood19(cells, opens, exit_ok);
    checks++;
    if (opens != 163) begin
      errors++;
      $display("FAIL z_open_count: got %0d, required 163", opens);
    end
    checks++;
    if (cells != 81 || exit_ok !== 1'b1) begin
      errors++;
      $display("FAIL z_connect: cells=%0d exit=%b, required 81 and 1", cells, exit_ok);
    end
    run19(16'hACE1, lat);
    snap19();
    same = 1'b1;
    for (int r = 0; r < 19; r++) if (m19[r] !== ref_a[r]) same = 1'b0;
    checks++;
    if (same !== 1'b1) begin
      errors++;
      $display("FAIL z_vs_default: got differing mazes, required identical");
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ones;
    @(negedge clk);
    if19.start = 1'b1;
    if19.seed  = 16'h1234;
    @(posedge clk);
    #1;
    if19.start = 1'b0;
    for (int n = 1; n <= 50; n++) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    ones = 1'b1;
    for (int r = 0; r < 19; r++) if (if19.maze[r] !== 19'h7FFFF) ones = 1'b0;
    checks++;
    if (ones !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_maze: got partial maze, required all ones");
    end
    checks++;
    if (if19.busy !== 1'b0 || if19.done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flags: busy=%b done=%b, required 0 0", if19.busy, if19.done);
    end
    @(negedge clk);
    rst = 1'b0;
    run19(16'h1234, lat);
    checks++;
    if (lat != 101) begin
      errors++;
      $display("FAIL rstmid_restart_latency: got %0d edges, required 101", lat);
    end
    snap19();
    for (int r = 0; r < 19; r++) ref_b[r] = m19[r];
  endtask

  task automatic test_start_while_busy();
    int lat;
    bit same;
    @(negedge clk);
    if19.start = 1'b1;
    if19.seed  = 16'h1234;
    @(posedge clk);
    #1;
    if19.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if19.start = (n == 30 || n == 70);
      if19.seed  = 16'hBEEF;
      @(posedge clk);
      #1;
      if19.start = 1'b0;
      if (if19.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 101) begin
      errors++;
      $display("FAIL busy_start_latency: got %0d edges, required 101", lat);
    end
    snap19();
    same = 1'b1;
    for (int r = 0; r < 19; r++) if (m19[r] !== ref_b[r]) same = 1'b0;
    checks++;
    if (same !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_maze: got changed maze, required seed 1234 maze");
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int low_bad;
    int cells;
    int opens;
    bit exit_ok;
    bit same;
    @(negedge clk);
    if19.start = 1'b1;
    if19.seed  = 16'hBEEF;
    @(posedge clk);
    #1;
    if19.start = 1'b0;
    checks++;
    if (if19.done !== 1'b0 || if19.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b, required 0 1", if19.done, if19.busy);
    end
    lat     = -1;
    low_bad = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (if19.done === 1'b1) begin
        lat = n;
        break;
      end
      if (if19.busy !== 1'b1) low_bad++;
    end
    checks++;
    if (lat != 101 || low_bad != 0) begin
      errors++;
      $display("FAIL b2b_latency: got %0d edges (%0d busy gaps), required 101 and 0",
               lat, low_bad);
    end
    snap19();
    same = 1'b1;
    for (int r = 0; r < 19; r++) if (m19[r] !== ref_b[r]) same = 1'b0;
    checks++;
    if (same !== 1'b0) begin
      errors++;
      $display("FAIL b2b_new_maze: got the previous maze, required a different one");
    end
    flood19(cells, opens, exit_ok);
    checks++;
    if (cells != 81 || opens != 163 || exit_ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_valid: cells=%0d opens=%0d exit=%b, required 81 163 1",
               cells, opens, exit_ok);
    end
  endtask

  task automatic test_random_seeds();
    int lat;
    int cells;
    int opens;
    bit exit_ok;
    bit side_ok;
    logic [15:0] s;
    for (int i = 0; i < 100; i++) begin
      s = 16'($urandom);
      run19(s, lat);
      snap19();
      checks++;
      if (lat != 101) begin
        errors++;
        $display("FAIL rnd_latency seed=%h: got %0d, required 101", s, lat);
      end
      checks++;
      if (m19[0] !== 19'h7FFFD || m19[18] !== 19'h5FFFF) begin
        errors++;
        $display("FAIL rnd_border_rows seed=%h: got %b / %b, required %b / %b",
                 s, m19[0], m19[18], 19'h7FFFD, 19'h5FFFF);
      end
      side_ok = 1'b1;
      for (int r = 0; r < 19; r++) begin
        if (m19[r][0] !== 1'b1 || m19[r][18] !== 1'b1) side_ok = 1'b0;
      end
      checks++;
      if (side_ok !== 1'b1) begin
        errors++;
        $display("FAIL rnd_border_cols seed=%h: got an open side, required walls", s);
      end
      flood19(cells, opens, exit_ok);
      checks++;
      if (cells != 81 || exit_ok !== 1'b1) begin
        errors++;
        $display("FAIL rnd_connect seed=%h: cells=%0d exit=%b, required 81 1",
                 s, cells, exit_ok);
      end
      checks++;
      if (opens != 163) begin
        errors++;
        $display("FAIL rnd_open_count seed=%h: got %0d, required 163", s, opens);
      end
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    if5.start  = 1'b0;
    if5.seed   = 16'h0000;
    if19.start = 1'b0;
    if19.seed  = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_small_seed1();
    test_small_seed4000();
    test_seed_zero();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    test_random_seeds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
